// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC sequencing, IR, skid buffer, branch/jump redirect
// One request outstanding at a time; redirects landing on an in-flight request drop its response.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_ext,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] faddr;
  logic [31:0] redir;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic        skid_valid;
  logic        discard;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        accept;
  logic        redirect;

  assign pc_inc   = pc_out + 32'd4;
  assign accept   = !inst_valid || !stall;
  assign redirect = inst_valid && !stall && (jump || branch);
  assign target   = jump ? {pc_inc[31:28], jump_target, 2'b00}
                         : pc_inc + (branch_ext << 2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (!redirect && imem_ready && !discard && !accept) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (!stall || !skid_valid) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == FETCH);
    imem_addr = faddr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      faddr      <= RESET_PC;
      redir      <= 32'd0;
      inst       <= 32'd0;
      pc_out     <= 32'd0;
      inst_valid <= 1'b0;
      discard    <= 1'b0;
      skid_data  <= 32'd0;
      skid_pc    <= 32'd0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
            if (imem_ready) begin
              faddr <= target;
            end else begin
              // faddr must stay put until the in-flight response retires
              discard <= 1'b1;
              redir   <= target;
            end
          end else if (imem_ready && discard) begin
            faddr   <= redir;
            discard <= 1'b0;
          end else if (imem_ready && accept) begin
            inst       <= imem_rdata;
            pc_out     <= faddr;
            inst_valid <= 1'b1;
            faddr      <= faddr + 32'd4;
          end else if (imem_ready) begin
            skid_data  <= imem_rdata;
            skid_pc    <= faddr;
            skid_valid <= 1'b1;
            faddr      <= faddr + 32'd4;
          end else if (!stall) begin
            inst_valid <= 1'b0;
          end
        end
        FULL: begin
          if (redirect) begin
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
            faddr      <= target;
          end else if (!stall && skid_valid) begin
            inst       <= skid_data;
            pc_out     <= skid_pc;
            inst_valid <= 1'b1;
            skid_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch against an architectural PC-sequence model
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_ext = 32'd0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc_out;

  int tests = 0;
  int fails = 0;
  int consumed = 0;
  int lat_max = 0;
  bit rnd = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .branch_ext(branch_ext),
    .jump(jump), .jump_target(jump_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .pc_out(pc_out)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h2001_23AD ^ (a * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: random latency per request, spurious ready while in reset
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        lat = 0;
      end else if (imem_req && lat == 0) begin
        imem_ready = 1'b1;
        imem_rdata = memf(imem_addr);
        lat = $urandom_range(lat_max, 0);
      end else begin
        imem_ready = 1'b0;
        if (imem_req && lat > 0) lat--;
      end
    end
  end

  // monitor: pops expected PC on each consumed instruction, checks protocol rules
  initial begin
    logic        p_req, p_rdy, p_valid, p_stall, p_rst;
    logic [31:0] p_addr, p_pc, p_inst, e, pc4, nxt;
    p_req = 0; p_rdy = 0; p_valid = 0; p_stall = 0; p_rst = 0;
    p_addr = 0; p_pc = 0; p_inst = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_q.push_back(RESET_PC);
      end else begin
        if (p_rst && p_req && !p_rdy) begin
          chk("req_held", imem_req, 1);
          chk("addr_stable", imem_addr, p_addr);
        end
        if (p_rst && p_valid && p_stall) begin
          chk("stall_valid_hold", inst_valid, 1);
          chk("stall_pc_hold", pc_out, p_pc);
          chk("stall_inst_hold", inst, p_inst);
        end
        if (inst_valid && !stall) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ir_unexpected: got pc %h expected none", pc_out);
          end else begin
            e = exp_q.pop_front();
            chk("ir_pc", pc_out, e);
            chk("ir_inst", inst, memf(e));
            consumed++;
            pc4 = e + 32'd4;
            if (jump)        nxt = {pc4[31:28], jump_target, 2'b00};
            else if (branch) nxt = pc4 + branch_ext * 32'd4;
            else             nxt = pc4;
            exp_q.push_back(nxt);
          end
        end
      end
      p_req = imem_req; p_rdy = imem_ready; p_valid = inst_valid; p_stall = stall;
      p_rst = rst_n; p_addr = imem_addr; p_pc = pc_out; p_inst = inst;
    end
  end

  task automatic cyc();
    logic [31:0] r;
    @(posedge clk);
    #2;
    if (rnd) begin
      r = $urandom;
      stall = ($urandom_range(99, 0) < 30);
      branch = ($urandom_range(99, 0) < 10);
      jump = ($urandom_range(99, 0) < 5);
      branch_ext = {{16{r[15]}}, r[15:0]};
      jump_target = r[31:6];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", pc_out, 0);
    rst_n = 1'b1;
    chk("idle_req", imem_req, 0);
    cyc();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RESET_PC);
    cyc();
    chk("first_valid", inst_valid, 1);
    chk("first_pc", pc_out, 0);
    chk("first_inst", inst, 32'h2001_23AD);

    // branch back by one word from 0x10
    n = 0;
    do begin cyc(); n++; end while (!(inst_valid && pc_out == 32'h10) && n < 50);
    chk("br_found", (n < 50), 1);
    branch = 1'b1; branch_ext = 32'hFFFF_FFFE;
    cyc();
    branch = 1'b0;
    chk("br_bubble", inst_valid, 0);
    chk("br_addr", imem_addr, 32'h0C);

    // branch to the last word to exercise address wrap
    n = 0;
    do begin cyc(); n++; end while (!(inst_valid && pc_out == 32'h10) && n < 50);
    chk("wrap_found", (n < 50), 1);
    branch = 1'b1; branch_ext = 32'hFFFF_FFFA;
    cyc();
    branch = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);

    // stall with memory ready fills the skid buffer
    stall = 1'b1;
    repeat (3) cyc();
    chk("full_req", imem_req, 0);
    chk("full_valid", inst_valid, 1);
    stall = 1'b0;
    repeat (4) cyc();

    // jump while a response is pending
    lat_max = 3;
    n = 0;
    do begin cyc(); n++; end while (!(inst_valid && imem_req && !imem_ready) && n < 200);
    chk("jmp_found", (n < 200), 1);
    jump = 1'b1; jump_target = 26'h40;
    cyc();
    jump = 1'b0;
    chk("jmp_bubble", inst_valid, 0);
    n = 0;
    while (!(imem_req && imem_addr == 32'h100) && n < 20) begin cyc(); n++; end
    chk("jmp_target_req", (n < 20), 1);
    repeat (6) cyc();

    // reset in the middle of a wait
    n = 0;
    do begin cyc(); n++; end while (!(imem_req && !imem_ready) && n < 200);
    chk("rst_mid_found", (n < 200), 1);
    rst_n = 1'b0;
    cyc();
    chk("rst_mid_req", imem_req, 0);
    chk("rst_mid_valid", inst_valid, 0);
    cyc();
    rst_n = 1'b1;
    chk("rst_mid_idle", imem_req, 0);
    cyc();
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, RESET_PC);

    rnd = 1'b1;
    repeat (4000) cyc();
    rnd = 1'b0;
    stall = 1'b0; branch = 1'b0; jump = 1'b0;
    repeat (20) cyc();
    chk("progress", (consumed > 500), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
